uart_tx_fifo: RTL and testbench

//  Buffered UART transmit channel: accepts parallel words on a valid/ready port, queues them in an

---
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with valid/ready input and back-to-back framing
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int    CLK_FRE    = 50_000_000,
    parameter int    BPS        = 9600,
    parameter string PARITY     = "NONE",
    parameter int    WIDTH      = 8,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_DIV = CLK_FRE / BPS;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int BW       = $clog2(WIDTH);
    localparam bit PAR_ODD  = (PARITY == "ODD");
    localparam bit PAR_EN   = PAR_ODD || (PARITY == "EVEN");
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];

    logic push, pop, baud_end, not_empty;

    always_comb begin
        push      = tx_valid && ready_q;
        pop       = 1'b0;
        baud_end  = (cnt_q == CNT_MAX);
        not_empty = (level_q != '0);
        state_d   = state_q;
        cnt_d     = baud_end ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_d     = par_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pop   = not_empty;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BW'(WIDTH - 1)) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (baud_end) begin
                    if (not_empty) pop = 1'b1;
                    else state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Popping loads the head word and starts the next frame on the same edge
        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            shreg_d = mem[rd_ptr_q];
            par_d   = PAR_ODD ? ~^mem[rd_ptr_q] : ^mem[rd_ptr_q];
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset; the pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    assign tx_ready   = ready_q;
    assign uart_tx    = tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with EVEN, ODD and NONE parity instances
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic [2:0] vld = '0;
    logic [2:0] rdy, line, busy, done;
    logic [2:0] lvl [3];
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [10:0] bits;
        int          gap_max;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [7:0]  T3_D [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    localparam logic [10:0] T3_F [5] = '{11'h602, 11'h604, 11'h406, 11'h608, 11'h40A};
    localparam logic [7:0]  T4_D [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    localparam logic [10:0] T4_F [5] = '{11'h422, 11'h444, 11'h466, 11'h488, 11'h4AA};

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FRE(160), .BPS(10), .PARITY("EVEN"), .WIDTH(8), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .uart_tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.CLK_FRE(160), .BPS(10), .PARITY("ODD"), .WIDTH(8), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .uart_tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.CLK_FRE(160), .BPS(10), .PARITY("NONE"), .WIDTH(8), .FIFO_DEPTH(4)) u_none (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .uart_tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]), .fifo_level(lvl[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Frame monitors: one per instance, each decodes a frame cycle by cycle from its start bit
    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin
            int          nb;
            int          gap;
            logic [10:0] bits;
            bit          stable, done_ok, aborted;
            exp_t        e;
            nb  = (g == 2) ? 10 : 11;
            gap = 1000;
            forever begin
                @(negedge clk);
                if (rst) begin
                    gap = 1000;
                end else if (line[g] === 1'b1) begin
                    if (gap < 1000) gap++;
                end else begin
                    bits = '0; stable = 1'b1; done_ok = 1'b1; aborted = 1'b0;
                    for (int c = 0; c < nb * 16; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c % 16 == 0) bits[c / 16] = line[g];
                        else if (line[g] !== bits[c / 16]) stable = 1'b0;
                        if (busy[g] !== 1'b1) stable = 1'b0;
                        if (done[g] !== (c == nb * 16 - 1)) done_ok = 1'b0;
                    end
                    if (aborted) begin
                        gap = 1000;
                    end else begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_frame dut=%0d bits=%0h", g, bits);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_dut", 32'(g), 32'(e.id));
                            chk("frame_bits", 32'(bits), 32'(e.bits));
                            chk("frame_bit_hold_busy", 32'(stable), 32'd1);
                            chk("frame_done_pulse", 32'(done_ok), 32'd1);
                            if (e.gap_max >= 0) chk("frame_gap_ok", 32'(gap <= e.gap_max), 32'd1);
                        end
                        gap = 0;
                    end
                end
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d, input logic [10:0] f, input int gmax);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        tx_data = d;
        vld[k]  = 1'b1;
        while (rdy[k] !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout dut=%0d data=%0h", k, d);
            vld[k] = 1'b0;
        end else begin
            e.id = k; e.bits = f; e.gap_max = gmax;
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic idle_valid();
        @(negedge clk);
        vld = '0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy != 3'b000) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int hi;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(line), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h7);
        chk("rst_level", 32'(lvl[0]), 32'd0);
        rst = 1'b0;

        // EVEN parity single word: pop one edge after the push
        push(0, 8'h55, 11'h4AA, -1);
        idle_valid();
        chk("t1_line_before_pop", 32'(line[0]), 32'd1);
        chk("t1_level_one", 32'(lvl[0]), 32'd1);
        @(negedge clk);
        chk("t1_line_start", 32'(line[0]), 32'd0);
        chk("t1_level_zero", 32'(lvl[0]), 32'd0);
        drain(400);

        push(1, 8'h55, 11'h6AA, -1);
        idle_valid();
        drain(400);
        push(2, 8'hA3, 11'h346, -1);
        idle_valid();
        drain(400);

        // Six words back to back, sixth waits for space
        for (int i = 0; i < 5; i++) push(0, T3_D[i], T3_F[i], (i == 0) ? -1 : 0);
        @(negedge clk);
        chk("t3_ready_low", 32'(rdy[0]), 32'd0);
        chk("t3_level_full", 32'(lvl[0]), 32'd4);
        push(0, 8'h06, 11'h40C, 0);
        idle_valid();
        drain(1500);

        // Hold 0xEE while full; it must land once, after the queued words
        for (int i = 0; i < 5; i++) push(0, T4_D[i], T4_F[i], (i == 0) ? -1 : 0);
        @(negedge clk);
        tx_data = 8'hEE;
        chk("t4_ready_low", 32'(rdy[0]), 32'd0);
        chk("t4_level_full", 32'(lvl[0]), 32'd4);
        push(0, 8'hEE, 11'h5DC, 0);
        idle_valid();
        chk("t4_level_after_accept", 32'(lvl[0]), 32'd4);
        drain(1500);

        // Reset during data bit 2 (a zero) of the second of three frames
        push(0, 8'h81, 11'h502, -1);
        push(0, 8'h42, 11'h484, 0);
        push(0, 8'h24, 11'h448, 0);
        idle_valid();
        repeat (236) @(negedge clk);
        chk("t5_line_low_before_rst", 32'(line[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_line_high", 32'(line[0]), 32'd1);
        chk("t5_async_level_zero", 32'(lvl[0]), 32'd0);
        chk("t5_async_busy_low", 32'(busy[0]), 32'd0);
        chk("t5_async_ready_high", 32'(rdy[0]), 32'd1);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (line[0] === 1'b1 && busy[0] === 1'b0) hi++;
        end
        chk("t5_idle_after_release", 32'(hi), 32'd500);
        chk("t5_level_after_release", 32'(lvl[0]), 32'd0);

        // Push landing on the tx_done edge of the last queued frame
        push(0, 8'h5A, 11'h4B4, -1);
        idle_valid();
        n = 0;
        while (done[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t6_done_seen", 32'(done[0]), 32'd1);
        begin
            exp_t e;
            e.id = 0; e.bits = 11'h478; e.gap_max = 1;
            exp_q.push_back(e);
        end
        tx_data = 8'h3C;
        vld[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        chk("t6_level_one", 32'(lvl[0]), 32'd1);
        @(negedge clk);
        chk("t6_level_zero", 32'(lvl[0]), 32'd0);
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog_timeout time=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
